// File: rtl/tanh_arbiter_pkg.sv
// ============================================================================
// Module  : tanh_arbiter_pkg
// Brief   : Shared types and widths for the tanh engine arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tanh_arbiter_pkg;

  localparam int X_W   = 17;
  localparam int RES_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Index width for a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tanh_arbiter_rr_select.sv
// ============================================================================
// Module  : rr_select
// Brief   : Combinational round-robin selector; search starts after last_grant.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_select
  import tanh_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_id,
  output logic             any
);

  int idx;

  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    any          = 1'b0;
    idx          = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!any && req[idx]) begin
        any               = 1'b1;
        grant_id          = ID_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tanh_arbiter.sv
// ============================================================================
// Module  : tanh_arbiter
// Brief   : Round-robin sharing of one tanh engine among N_REQ requesters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tanh_arbiter
  import tanh_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [X_W*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [RES_W-1:0]       resp_result,
  output logic                   resp_err,
  output logic                   eng_start,
  output logic [X_W-1:0]         eng_data_x,
  input  logic                   eng_done,
  input  logic [RES_W-1:0]       eng_result,
  output logic                   busy
);

  localparam int                ID_W     = id_width(N_REQ);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [ID_W-1:0]   LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cur_id;
  logic [CNT_W-1:0]  wait_cnt;
  logic              err_flag;

  logic [N_REQ-1:0]  sel_onehot;
  logic [ID_W-1:0]   sel_id;
  logic              sel_any;

  rr_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_select (
    .req          (req_valid),
    .last_grant   (last_grant),
    .grant_onehot (sel_onehot),
    .grant_id     (sel_id),
    .any          (sel_any)
  );

  // Acceptance is visible in the same IDLE cycle the grant is taken.
  assign req_ready = (state == ST_IDLE) ? sel_onehot : '0;
  assign busy      = (state != ST_IDLE);
  assign resp_err  = (state == ST_RESP) && err_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= LAST_RST;
      cur_id      <= '0;
      wait_cnt    <= '0;
      err_flag    <= 1'b0;
      resp_result <= '0;
      eng_data_x  <= '0;
      eng_start   <= 1'b0;
      resp_valid  <= '0;
    end else begin
      eng_start  <= 1'b0;
      resp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_any) begin
            cur_id     <= sel_id;
            eng_data_x <= req_x[int'(sel_id)*X_W +: X_W];
            eng_start  <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion on the last allowed cycle still counts as success.
          if (eng_done) begin
            resp_result <= eng_result;
            err_flag    <= 1'b0;
            resp_valid  <= N_REQ'(1) << cur_id;
            state       <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            resp_result <= '0;
            err_flag    <= 1'b1;
            resp_valid  <= N_REQ'(1) << cur_id;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          last_grant <= cur_id;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
